// File: rtl/sym_pkg.sv
// Shared constants for the 2-bit symbol frame transmitter: symbol width,
// FSM state encoding and the fixed preamble symbols.
package sym_pkg;

  localparam int SYM_W = 2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE0 = 3'd1;
  localparam logic [2:0] ST_PRE1 = 3'd2;
  localparam logic [2:0] ST_PRE2 = 3'd3;
  localparam logic [2:0] ST_DATA = 3'd4;
  localparam logic [2:0] ST_PAR  = 3'd5;

  localparam logic [SYM_W-1:0] SYM_P0 = 2'b01;
  localparam logic [SYM_W-1:0] SYM_P1 = 2'b10;
  localparam logic [SYM_W-1:0] SYM_P2 = 2'b11;

endpackage

// File: rtl/sym_shifter.sv
// Parallel-load payload register that shifts left one symbol at a time and
// presents its most significant symbol.
module sym_shifter
  import sym_pkg::*;
#(
  parameter int NSYM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [SYM_W*NSYM-1:0] i_data,
  output logic [SYM_W-1:0]      o_sym
);

  logic [SYM_W*NSYM-1:0] r_data;

  // Load wins over shift so a fresh frame never sees stale payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= r_data << SYM_W;
    end
  end

  assign o_sym = r_data[SYM_W*NSYM-1 -: SYM_W];

endmodule

// File: rtl/sym_frame_tx.sv
// Frame transmitter: preamble 01,10,11 then PAYLOAD_SYMS payload symbols over a
// valid/ready handshake. Define SYM_PARITY_EN to append an XOR parity symbol.
module sym_frame_tx
  import sym_pkg::*;
#(
  parameter int               PAYLOAD_SYMS = 4,
  parameter logic [SYM_W-1:0] IDLE_SYM     = 2'b00
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [SYM_W*PAYLOAD_SYMS-1:0] payload,
  input  logic                          num_ready,
  output logic [SYM_W-1:0]              num_out,
  output logic                          num_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int CNT_W = (PAYLOAD_SYMS > 1) ? $clog2(PAYLOAD_SYMS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PAYLOAD_SYMS - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             w_xfer;
  logic             w_load;
  logic             w_shift;
  logic [SYM_W-1:0] w_shSym;

  assign w_xfer  = num_valid && num_ready;
  assign w_load  = (r_state == ST_IDLE) && start;
  assign w_shift = w_xfer && (r_state == ST_DATA);

  sym_shifter #(
    .NSYM (PAYLOAD_SYMS)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (payload),
    .o_sym   (w_shSym)
  );

`ifdef SYM_PARITY_EN
  logic [SYM_W-1:0] r_parity;
  logic [SYM_W-1:0] w_parity;

  always_comb begin
    w_parity = '0;
    for (int k = 0; k < PAYLOAD_SYMS; k++) begin
      w_parity = w_parity ^ payload[k*SYM_W +: SYM_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= '0;
    end else if (w_load) begin
      r_parity <= w_parity;
    end
  end
`endif

  // Every state after IDLE advances only on a completed transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_PRE0;
            r_cnt   <= CNT_LOAD;
          end
        end
        ST_PRE0: if (w_xfer) r_state <= ST_PRE1;
        ST_PRE1: if (w_xfer) r_state <= ST_PRE2;
        ST_PRE2: if (w_xfer) r_state <= ST_DATA;
        ST_DATA: begin
          if (w_xfer) begin
            if (r_cnt == '0) begin
`ifdef SYM_PARITY_EN
              r_state <= ST_PAR;
`else
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
`endif
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
`ifdef SYM_PARITY_EN
        ST_PAR: begin
          if (w_xfer) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    num_out = IDLE_SYM;
    case (r_state)
      ST_PRE0: num_out = SYM_P0;
      ST_PRE1: num_out = SYM_P1;
      ST_PRE2: num_out = SYM_P2;
      ST_DATA: num_out = w_shSym;
`ifdef SYM_PARITY_EN
      ST_PAR:  num_out = r_parity;
`endif
      default: num_out = IDLE_SYM;
    endcase
  end

  assign num_valid = (r_state != ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_sym_frame_tx.sv
// Scoreboard bench for sym_frame_tx: expected symbols are queued when a frame is
// requested and compared on every cycle; a golden 01,10,11 detector watches num_out.
module tb_sym_frame_tx;

  localparam int P = 4;
  localparam logic [1:0] IDLE_SYM = 2'b00;
`ifdef SYM_PARITY_EN
  localparam int FRAME_LEN = 3 + P + 1;
`else
  localparam int FRAME_LEN = 3 + P;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           num_ready = 1'b0;
  logic [2*P-1:0] payload = '0;
  logic [1:0]     num_out;
  logic           num_valid;
  logic           busy;
  logic           done;

  typedef struct {
    logic [1:0] sym;
    bit         last;
    int         idx;
  } symEntry_t;

  symEntry_t expQ[$];
  symEntry_t monEntry;
  int        assertCount = 0;
  int        failCount = 0;
  bit        monOn = 1'b0;
  logic      doneExp = 1'b0;
  logic      nextDone;
  int        detState = 0;
  logic      detOut = 1'b0;

  sym_frame_tx #(
    .PAYLOAD_SYMS (P),
    .IDLE_SYM     (IDLE_SYM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .payload   (payload),
    .num_ready (num_ready),
    .num_out   (num_out),
    .num_valid (num_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task pushFrame(input logic [2*P-1:0] pl);
    symEntry_t e;
    logic [1:0] par;
    par = '0;
    e.last = 1'b0;
    e.sym = 2'b01; e.idx = 0; expQ.push_back(e);
    e.sym = 2'b10; e.idx = 1; expQ.push_back(e);
    e.sym = 2'b11; e.idx = 2; expQ.push_back(e);
    for (int k = 0; k < P; k++) begin
      e.sym = pl[2*(P-1-k) +: 2];
      par = par ^ e.sym;
      e.idx = 3 + k;
`ifdef SYM_PARITY_EN
      e.last = 1'b0;
`else
      e.last = (k == P - 1);
`endif
      expQ.push_back(e);
    end
`ifdef SYM_PARITY_EN
    e.sym = par; e.idx = 3 + P; e.last = 1'b1;
    expQ.push_back(e);
`endif
  endtask

  // Per-cycle scoreboard: outputs must match the queue head, transfers pop it,
  // and done must pulse exactly one cycle after a frame's last transfer.
  always @(negedge clk) begin
    if (rst_n && monOn) begin
      checkOutput("done", 32'(done), 32'(doneExp));
      nextDone = 1'b0;
      if (expQ.size() == 0) begin
        checkOutput("idleValid", 32'(num_valid), 32'(0));
        checkOutput("idleSym", 32'(num_out), 32'(IDLE_SYM));
        checkOutput("idleBusy", 32'(busy), 32'(0));
      end else begin
        checkOutput("valid", 32'(num_valid), 32'(1));
        checkOutput("busy", 32'(busy), 32'(1));
        checkOutput("sym", 32'(num_out), 32'(expQ[0].sym));
        if (num_valid && num_ready) begin
          monEntry = expQ.pop_front();
          if (monEntry.idx == 0) begin
            detState = 0;
            detOut = 1'b0;
          end
          case (detState)
            1:       detState = (num_out == 2'b10) ? 2 : ((num_out == 2'b01) ? 1 : 0);
            2: begin
              if (num_out == 2'b11) detOut = 1'b1;
              detState = (num_out == 2'b01) ? 1 : 0;
            end
            default: detState = (num_out == 2'b01) ? 1 : 0;
          endcase
          if (monEntry.idx == 2) checkOutput("detectAfterPre2", 32'(detOut), 32'(1));
          if (monEntry.idx < 2) checkOutput("detectEarly", 32'(detOut), 32'(0));
          nextDone = monEntry.last;
        end
      end
      doneExp = nextDone;
    end
  end

  task applyStimulus(input logic [2*P-1:0] pl, input int mode, input int expCycles);
    int cyc;
    bit seen;
    @(posedge clk); #1;
    payload = pl;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    payload = ~pl;
    pushFrame(pl);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      case (mode)
        0:       num_ready = 1'b1;
        1:       num_ready = (cyc % 2 == 1);
        default: num_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput("doneSeen", 32'(seen), 32'(1));
    if (expCycles > 0) checkOutput("frameCycles", 32'(cyc), 32'(expCycles));
  endtask

  task waitEmpty(input string tag);
    for (int i = 0; i < 200 && expQ.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    checkOutput(tag, 32'(expQ.size()), 32'(0));
  endtask

  initial begin
    #12;
    checkOutput("rstValid", 32'(num_valid), 32'(0));
    checkOutput("rstSym", 32'(num_out), 32'(IDLE_SYM));
    checkOutput("rstBusy", 32'(busy), 32'(0));
    checkOutput("rstDone", 32'(done), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    monOn = 1'b1;

    $display("[TB] back-to-back ready, payload E4");
    applyStimulus(8'hE4, 0, FRAME_LEN + 1);
    $display("[TB] toggling ready, payload E4");
    applyStimulus(8'hE4, 1, 2 * FRAME_LEN + 1);
    $display("[TB] payloads containing preamble symbols");
    applyStimulus(8'h1B, 0, FRAME_LEN + 1);
    applyStimulus(8'h6C, 1, 2 * FRAME_LEN + 1);

    $display("[TB] start held high across a frame");
    num_ready = 1'b1;
    @(posedge clk); #1;
    payload = 8'h93;
    start = 1'b1;
    @(posedge clk); #1;
    pushFrame(8'h93);
    payload = 8'h5A;
    waitEmpty("heldFrameA");
    @(posedge clk);
    @(posedge clk); #1;
    pushFrame(8'h5A);
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    waitEmpty("heldFrameB");
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset during DATA");
    payload = 8'hC3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pushFrame(8'hC3);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("preRstBusy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", 32'(num_valid), 32'(0));
    checkOutput("midRstSym", 32'(num_out), 32'(IDLE_SYM));
    checkOutput("midRstBusy", 32'(busy), 32'(0));
    checkOutput("midRstDone", 32'(done), 32'(0));
    expQ.delete();
    doneExp = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    applyStimulus(8'h27, 0, FRAME_LEN + 1);

    $display("[TB] random payloads with random ready");
    for (int n = 0; n < 4; n++) begin
      applyStimulus(8'($urandom), 2, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
